// File: rtl/ide_strobe_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ide_strobe_receiver_pkg
// Description : Shared types and constants for the IDE strobe receiver:
//               access-tracking FSM states, pin index map into the filter
//               bank, reg_sel field layout and common ATA register selects.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ide_strobe_receiver_pkg;

    // Access-tracking FSM
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WRITE  = 2'd2,
        S_HRESET = 2'd3
    } state_t;

    // Position of each host pin in the filter bank
    localparam int c_pin_dior  = 0;
    localparam int c_pin_diow  = 1;
    localparam int c_pin_dmack = 2;
    localparam int c_pin_reset = 3;
    localparam int c_pin_cs0   = 4;
    localparam int c_pin_cs1   = 5;
    localparam int c_pin_da0   = 6;
    localparam int c_num_pins  = 9;

    // reg_sel = {~cs1, ~cs0, da[2:0]}
    localparam int c_regsel_w      = 5;
    localparam int c_regsel_da_lsb = 0;
    localparam int c_regsel_cs0    = 3;
    localparam int c_regsel_cs1    = 4;

    // Common ATA register selects
    localparam logic [4:0] c_reg_data       = 5'b01_000;
    localparam logic [4:0] c_reg_status_cmd = 5'b01_111;
    localparam logic [4:0] c_reg_altstat    = 5'b10_110;

    // A PIO access decodes only when exactly one chip select is asserted
    function automatic logic pio_cs_valid(input logic [c_regsel_w-1:0] sel);
        return sel[c_regsel_cs1] ^ sel[c_regsel_cs0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ide_strobe_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : ide_strobe_receiver_if
// Description : Host-driven IDE control/address pins as seen by the device.
//               master = host side (drives pins), slave = device receiver.
// Signals     : ide_dior_n, ide_diow_n, ide_dmack_n, ide_cs_n[1:0] {CS1-,CS0-},
//               ide_da[2:0], ide_reset_n -- all asynchronous to clk
// Revision    : 1.0 - initial release
// ============================================================================
interface ide_strobe_receiver_if;
    logic       ide_dior_n;
    logic       ide_diow_n;
    logic       ide_dmack_n;
    logic [1:0] ide_cs_n;
    logic [2:0] ide_da;
    logic       ide_reset_n;

    modport master (
        output ide_dior_n, ide_diow_n, ide_dmack_n, ide_cs_n, ide_da, ide_reset_n
    );

    modport slave (
        input  ide_dior_n, ide_diow_n, ide_dmack_n, ide_cs_n, ide_da, ide_reset_n
    );
endinterface
`default_nettype wire

// File: rtl/ide_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : ide_input_filter
// Description : One-bit synchroniser followed by a deglitch counter. The
//               filtered level follows the synced pin only after FILTER_LEN
//               consecutive samples that differ from the current level.
// Ports       : clk, rst_n   - clock, async active-low reset
//               pin          - asynchronous input
//               level        - filtered level (resets to RST_VAL)
//               fall / rise  - one-cycle pulses coincident with level change
// Revision    : 1.0 - initial release
// ============================================================================
module ide_input_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter logic RST_VAL     = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic pin,
    output logic      level,
    output logic      fall,
    output logic      rise
);

    localparam int               c_cnt_w   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_fall;
    logic                   r_rise;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= {SYNC_STAGES{RST_VAL}};
            r_cnt   <= '0;
            r_level <= RST_VAL;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
            r_fall <= 1'b0;
            r_rise <= 1'b0;
            if (w_synced == r_level) begin
                // Any sample agreeing with the current level restarts the count
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= w_synced;
                r_cnt   <= '0;
                r_fall  <= ~w_synced;
                r_rise  <= w_synced;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign level = r_level;
    assign fall  = r_fall;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/ide_strobe_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ide_strobe_receiver
// Description : Device-side receiver for host IDE control lines. Filters every
//               pin, tracks host accesses in a small FSM and emits registered
//               single-cycle access events with the latched register select.
// Ports       : clk, rst_n            - clock, async active-low reset
//               bus (slave modport)   - DIOR-/DIOW-/DMACK-/CS-/DA/RESET- pins
//               reg_sel[4:0]          - {~cs1,~cs0,da} latched at strobe fall
//               pio_rd_start/end, pio_wr, dma_rd_start/end, dma_wr - pulses
//               rd_active             - read in progress (level)
//               host_reset            - filtered RESET- asserted (level)
//               proto_err             - illegal strobe combination (pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module ide_strobe_receiver
    import ide_strobe_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ide_strobe_receiver_if.slave  bus,
    output logic [c_regsel_w-1:0] reg_sel,
    output logic                  pio_rd_start,
    output logic                  pio_rd_end,
    output logic                  pio_wr,
    output logic                  dma_rd_start,
    output logic                  dma_rd_end,
    output logic                  dma_wr,
    output logic                  rd_active,
    output logic                  host_reset,
    output logic                  proto_err
);

    logic [c_num_pins-1:0] w_pins;
    logic [c_num_pins-1:0] w_lvl;
    logic [c_num_pins-1:0] w_fall;
    logic [c_num_pins-1:0] w_rise;
    logic [13:0]           w_unused_edges;

    assign w_pins = {bus.ide_da, bus.ide_cs_n, bus.ide_reset_n,
                     bus.ide_dmack_n, bus.ide_diow_n, bus.ide_dior_n};

    // Active-low pins idle high; address lines idle low
    for (genvar gi = 0; gi < c_num_pins; gi++) begin : g_pin_filter
        ide_input_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .RST_VAL     ((gi < c_pin_da0) ? 1'b1 : 1'b0)
        ) u_filter (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (w_pins[gi]),
            .level (w_lvl[gi]),
            .fall  (w_fall[gi]),
            .rise  (w_rise[gi])
        );
    end

    // Only the strobe edges drive the FSM; other pins are used as levels
    assign w_unused_edges = {w_fall[c_num_pins-1:c_pin_dmack],
                             w_rise[c_num_pins-1:c_pin_dmack]};

    logic                  w_dior_lvl, w_diow_lvl, w_reset_lvl;
    logic                  w_dior_fall, w_diow_fall, w_dior_rise, w_diow_rise;
    logic [c_regsel_w-1:0] w_sel_now;

    assign w_dior_lvl  = w_lvl[c_pin_dior];
    assign w_diow_lvl  = w_lvl[c_pin_diow];
    assign w_reset_lvl = w_lvl[c_pin_reset];
    assign w_dior_fall = w_fall[c_pin_dior];
    assign w_diow_fall = w_fall[c_pin_diow];
    assign w_dior_rise = w_rise[c_pin_dior];
    assign w_diow_rise = w_rise[c_pin_diow];
    assign w_sel_now   = {~w_lvl[c_pin_cs1], ~w_lvl[c_pin_cs0],
                          w_lvl[c_pin_da0+2:c_pin_da0]};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_regsel_w-1:0] r_reg_sel;
    logic                  r_dma;
    logic                  w_latch, w_start, w_end, w_wr, w_err;
    logic                  w_dma_sel, w_pio_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_wr        = 1'b0;
        w_err       = 1'b0;
        if (!w_reset_lvl) begin
            // Bus reset aborts any access without an end event
            w_state_nxt = S_HRESET;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dior_fall || w_diow_fall) begin
                        // Both strobes low after the new edge covers a
                        // simultaneous fall as well as a fall onto a held strobe
                        if (!w_dior_lvl && !w_diow_lvl) begin
                            w_err = 1'b1;
                        end else begin
                            w_latch = 1'b1;
                            if (w_dior_fall) begin
                                w_state_nxt = S_READ;
                                w_start     = 1'b1;
                            end else begin
                                w_state_nxt = S_WRITE;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (w_diow_fall) begin
                        w_err = 1'b1;
                    end
                    if (w_dior_rise) begin
                        w_state_nxt = S_IDLE;
                        w_end       = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_dior_fall) begin
                        w_err = 1'b1;
                    end
                    if (w_diow_rise) begin
                        w_state_nxt = S_IDLE;
                        w_wr        = 1'b1;
                    end
                end
                S_HRESET: begin
                    if (w_dior_lvl && w_diow_lvl) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Start events use the live pin state; end events use what was latched
    assign w_dma_sel = w_latch ? ~w_lvl[c_pin_dmack] : r_dma;
    assign w_pio_ok  = pio_cs_valid(w_latch ? w_sel_now : r_reg_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    logic r_pio_rd_start, r_pio_rd_end, r_pio_wr;
    logic r_dma_rd_start, r_dma_rd_end, r_dma_wr;
    logic r_rd_active, r_host_reset, r_proto_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_sel      <= '0;
            r_dma          <= 1'b0;
            r_pio_rd_start <= 1'b0;
            r_pio_rd_end   <= 1'b0;
            r_pio_wr       <= 1'b0;
            r_dma_rd_start <= 1'b0;
            r_dma_rd_end   <= 1'b0;
            r_dma_wr       <= 1'b0;
            r_rd_active    <= 1'b0;
            r_host_reset   <= 1'b0;
            r_proto_err    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_reg_sel <= w_sel_now;
                r_dma     <= ~w_lvl[c_pin_dmack];
            end
            r_pio_rd_start <= w_start & ~w_dma_sel & w_pio_ok;
            r_pio_rd_end   <= w_end   & ~w_dma_sel & w_pio_ok;
            r_pio_wr       <= w_wr    & ~w_dma_sel & w_pio_ok;
            r_dma_rd_start <= w_start &  w_dma_sel;
            r_dma_rd_end   <= w_end   &  w_dma_sel;
            r_dma_wr       <= w_wr    &  w_dma_sel;
            r_rd_active    <= (w_state_nxt == S_READ);
            r_host_reset   <= ~w_reset_lvl;
            r_proto_err    <= w_err;
        end
    end

    assign reg_sel      = r_reg_sel;
    assign pio_rd_start = r_pio_rd_start;
    assign pio_rd_end   = r_pio_rd_end;
    assign pio_wr       = r_pio_wr;
    assign dma_rd_start = r_dma_rd_start;
    assign dma_rd_end   = r_dma_rd_end;
    assign dma_wr       = r_dma_wr;
    assign rd_active    = r_rd_active;
    assign host_reset   = r_host_reset;
    assign proto_err    = r_proto_err;

endmodule
`default_nettype wire
